// File: rtl/adq_readout.sv
// Acquisition-memory readout: streams words 0..last_add from a synchronous RAM
// to a valid/ready sink, one word per RD -> WAIT -> OUT pass.
module adq_readout #(
  parameter int DATA_W = 32,
  parameter int ADD_S  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic [ADD_S-1:0]  last_add,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADD_S-1:0]  mem_add,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADD_S-1:0] ADD_ONE = {{(ADD_S-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADD_S-1:0]    r_cnt;
  logic [ADD_S-1:0]    r_last;
  logic [DATA_W-1:0]   r_dout;
  logic                r_mem_en;
  logic                r_dout_valid;
  logic                r_busy;
  logic                r_done;

  // Handshake: a word transfers on a rising edge where dout_valid and
  // dout_ready are both 1; dout_valid never drops and dout never changes before that.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last       <= '0;
      r_dout       <= '0;
      r_mem_en     <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init) begin
            r_state  <= S_RD;
            r_cnt    <= '0;
            r_last   <= last_add;
            r_mem_en <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_RD: begin
          r_state  <= S_WAIT;
          r_mem_en <= 1'b0;
        end
        S_WAIT: begin
          r_state      <= S_OUT;
          r_dout       <= mem_data;
          r_dout_valid <= 1'b1;
        end
        S_OUT: begin
          if (dout_ready) begin
            r_dout_valid <= 1'b0;
            // Stopping on equality keeps the counter from wrapping at full depth.
            if (r_cnt == r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_RD;
              r_cnt    <= r_cnt + ADD_ONE;
              r_mem_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_mem_en     <= 1'b0;
          r_dout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_wr     = 1'b0;
  assign mem_add    = r_cnt;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_adq_readout.sv
// Bench for adq_readout: synchronous RAM model, expected-word queue built from
// the memory image, and directed plus randomized readouts.
`timescale 1ns/1ps
module tb_adq_readout;
  localparam int DATA_W = 32;
  localparam int ADD_S  = 8;
  localparam int DEPTH  = 1 << ADD_S;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              init = 1'b0;
  logic [ADD_S-1:0]  last_add = '0;
  logic              mem_en;
  logic              mem_wr;
  logic [ADD_S-1:0]  mem_add;
  logic [DATA_W-1:0] mem_data = '0;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  adq_readout #(.DATA_W(DATA_W), .ADD_S(ADD_S)) dut (
    .clk(clk), .rst(rst), .init(init), .last_add(last_add),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_add(mem_add), .mem_data(mem_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / cycle counter / memory
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_data <= mem[mem_add];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic preload_dec();
    for (int a = 0; a < DEPTH; a++) mem[a] = 32'hFFFF_FFFF - 32'(a);
  endtask

  task automatic preload_rand();
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mem_en"}, 32'(mem_en), 0);
    chk({pfx, "_mem_wr"}, 32'(mem_wr), 0);
    chk({pfx, "_mem_add"}, 32'(mem_add), 0);
    chk({pfx, "_dout"}, dout, 0);
    chk({pfx, "_dout_valid"}, 32'(dout_valid), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
  endtask

  // One readout of words 0..last. Options (-1 = off): stall_at holds ready low
  // for 5 OUT cycles at that address, poke_at pulses init there, abort_at
  // asserts reset in WAIT there.
  task automatic do_run(input int last, input int rnd_ready, input int stall_at,
                        input int poke_at, input int abort_at);
    int first_rd, first_v, prev_v, last_hs, done_cyc, n_done, stall_n, prev_add, widx;
    int order_ok, space_ok, hold_ok, wr_ok, stall_ok, poked, pend, finished, aborted;
    logic [DATA_W-1:0] held;
    exp_q.delete();
    for (int a = 0; a <= last; a++) exp_q.push_back(mem[a]);
    first_v = -1; prev_v = -1; last_hs = -10; done_cyc = -1; n_done = 0; stall_n = 0;
    prev_add = 0; widx = 0; order_ok = 1; space_ok = 1; hold_ok = 1; wr_ok = 1;
    stall_ok = 1; poked = 0; pend = 0; finished = 0; aborted = 0;

    @(negedge clk);
    held = dout;
    last_add = ADD_S'(last);
    init = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    init = 1'b0;
    last_add = ADD_S'($urandom);
    first_rd = cyc;
    chk("start_mem_en", 32'(mem_en), 1);
    chk("start_addr", 32'(mem_add), 0);
    chk("start_busy", 32'(busy), 1);

    for (int t = 0; t < 40 * (last + 2) && finished == 0; t++) begin
      if (t > 0) @(negedge clk);
      if (abort_at >= 0 && busy && !mem_en && !dout_valid && !done && int'(mem_add) == abort_at) begin
        rst = 1'b0;
        init = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (done || busy) n_done++;
        end
        chk("abort_quiet", n_done, 0);
        aborted = 1;
        finished = 1;
      end else begin
        if (mem_wr !== 1'b0) wr_ok = 0;
        if (int'(mem_add) != prev_add && int'(mem_add) != prev_add + 1) order_ok = 0;
        if (int'(mem_add) > last) order_ok = 0;
        prev_add = int'(mem_add);
        if (pend != 0 && !(dout_valid && dout === held)) hold_ok = 0;
        if (!dout_valid && dout !== held) hold_ok = 0;

        if (dout_valid && stall_at >= 0 && int'(mem_add) == stall_at && stall_n < 5) begin
          dout_ready = 1'b0;
          stall_n++;
          if (dout !== mem[stall_at] || mem_en !== 1'b0) stall_ok = 0;
        end else begin
          dout_ready = (rnd_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        if (poke_at >= 0 && poked == 0 && busy && int'(mem_add) == poke_at) begin
          init = 1'b1;
          poked = 1;
        end else begin
          init = 1'b0;
        end

        if (dout_valid) begin
          if (first_v < 0) first_v = cyc;
          if (pend == 0) begin
            if (prev_v >= 0 && cyc - prev_v != 3) space_ok = 0;
            prev_v = cyc;
          end
          held = dout;
          if (dout_ready) begin
            if (exp_q.size() == 0) chk("extra_word", 1, 0);
            else chk($sformatf("word%0d", widx), dout, exp_q.pop_front());
            widx++;
            last_hs = cyc;
            pend = 0;
          end else begin
            pend = 1;
          end
        end else begin
          pend = 0;
        end

        if (done) begin
          n_done++;
          done_cyc = cyc;
          chk("done_after_hs", cyc - last_hs, 1);
        end else if (n_done > 0) begin
          chk("idle_after_done", 32'(busy), 0);
          chk("final_addr", 32'(mem_add), last);
          finished = 1;
        end
      end
    end
    init = 1'b0;

    if (finished == 0) chk("timeout", 0, 1);
    else if (aborted == 0) begin
      chk("all_words", exp_q.size(), 0);
      chk("done_count", n_done, 1);
      chk("addr_order", order_ok, 1);
      chk("dout_hold", hold_ok, 1);
      chk("mem_wr_zero", wr_ok, 1);
      chk("valid_latency", first_v - first_rd, 2);
      if (rnd_ready == 0 && stall_at < 0) begin
        chk("spacing", space_ok, 1);
        chk("rd_to_done", done_cyc - first_rd, 3 * (last + 1));
      end
      if (stall_at >= 0) begin
        chk("stall_cycles", stall_n, 5);
        chk("stall_hold", stall_ok, 1);
      end
    end
  endtask

  initial begin
    preload_dec();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // reset beats init
    init = 1'b1;
    last_add = ADD_S'(3);
    @(negedge clk);
    chk("rst_over_init_busy", 32'(busy), 0);
    chk("rst_over_init_en", 32'(mem_en), 0);
    init = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_init", 32'(busy), 0);

    do_run(3, 0, -1, -1, -1);
    do_run(0, 0, -1, -1, -1);
    do_run(DEPTH - 1, 0, -1, -1, -1);
    do_run(4, 0, 2, -1, -1);
    do_run(4, 0, -1, 1, -1);
    do_run(8, 0, -1, -1, 5);
    do_run(2, 0, -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      preload_rand();
      do_run($urandom_range(0, 20), 1, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adq_readout.md
ADQ_READOUT -- requirements
Module: adq_readout

Interface
REQ-001 Parameter DATA_W, default 32, sample word width; SHALL match the acquisition memory data width.
REQ-002 Parameter ADD_S, default 8, memory address width; SHALL give a depth of 2^ADD_S words.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 init  input  1  start pulse; sampled only in IDLE.
REQ-006 last_add  input  ADD_S  last address to read; latched on an accepted init.
REQ-007 mem_en  output  1  memory chip select.
REQ-008 mem_wr  output  1  memory write enable; SHALL be constant 0.
REQ-009 mem_add  output  ADD_S  memory read address.
REQ-010 mem_data  input  DATA_W  memory read data, valid one cycle after an mem_en=1 cycle.
REQ-011 dout  output  DATA_W  streamed sample.
REQ-012 dout_valid  output  1  dout holds a sample.
REQ-013 dout_ready  input  1  downstream accepts dout.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle end-of-readout pulse.

Function
REQ-016 The FSM SHALL have states IDLE, RD, WAIT, OUT and DONE, encoded in 3 bits.
REQ-017 IDLE: init=1 -> RD; address counter cleared to 0; last_add latched into an internal register.
REQ-018 IDLE: init=0 -> remain in IDLE.
REQ-019 RD: mem_en=1, mem_add=counter; next state WAIT, unconditionally.
REQ-020 WAIT: mem_en=0; mem_data captured into the dout register at the end of the cycle; next state OUT.
REQ-021 OUT: dout_valid=1; dout stable while dout_ready=0.
REQ-022 OUT with dout_ready=1 at the edge, counter<latched last -> counter+1 -> RD.
REQ-023 OUT with dout_ready=1 at the edge, counter==latched last -> DONE; counter not incremented.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE.
REQ-025 Latency: init seen at edge k -> RD in cycle k+1 -> dout_valid=1 from cycle k+3.
REQ-026 Throughput SHALL be 3 cycles per word when dout_ready is held at 1.
REQ-027 Addresses SHALL be read strictly ascending from 0 to the latched last, with no wrap.
REQ-028 last_add=0 -> exactly one word read.
REQ-029 last_add=2^ADD_S-1 -> all words read; the counter SHALL NOT overflow.
REQ-030 init while busy=1 SHALL be ignored.
REQ-031 last_add changes while busy SHALL NOT affect the current readout.
REQ-032 dout_valid SHALL NOT drop in OUT without a handshake.
REQ-033 dout SHALL hold its last value in IDLE, RD and WAIT.
REQ-034 mem_add SHALL equal the counter in all states.

Reset
REQ-035 rst=0 at an edge -> state IDLE, counter 0, latched last 0, dout 0, and all outputs 0 (mem_en, mem_wr, mem_add, dout_valid, busy, done) on the following cycle.
REQ-036 rst=0 mid-readout SHALL abort the readout with no done pulse.
REQ-037 rst has priority over init when both are asserted.
REQ-038 After rst returns to 1, the next init SHALL start again from address 0.

Verification
REQ-039 Reset then init with last_add=3, ready=1, memory preloaded with FFFFFFFF-addr -> dout sequence FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC; each valid for one cycle, 3 cycles apart; done one cycle after the last handshake.
REQ-040 last_add=0 -> exactly one word FFFFFFFF, then done, then busy=0.
REQ-041 last_add=FF, ready=1 -> 256 words, last word FFFFFF00; mem_add never exceeds FF; 768 cycles from first RD to DONE.
REQ-042 ready=0 for 5 cycles in OUT at address 2 -> dout=FFFFFFFD and dout_valid=1 held constant for 5 cycles; mem_en=0 throughout.
REQ-043 init pulsed at address 1 while busy -> ignored, readout continues to last with no restart.
REQ-044 rst=0 in WAIT at address 5 -> next cycle all outputs 0; no done pulse; a new init reads from address 0.
